// File: rtl/vga_timing_if.sv
// Pixel-side bundle for vga_timing: scan coordinates out to the compositor,
// the returned pixel in, and the panel strobes/data out.
// master = timing generator, slave = compositor/panel side.
interface vga_timing_if;
   logic [23:0] pixel_in;
   logic        test_mode;
   logic [10:0] vga_h;
   logic [10:0] vga_v;
   logic [23:0] rgb_out;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic        frame_start;

   modport master (
      input  pixel_in, test_mode,
      output vga_h, vga_v, rgb_out, de, hsync, vsync, frame_start
   );

   modport slave (
      output pixel_in, test_mode,
      input  vga_h, vga_v, rgb_out, de, hsync, vsync, frame_start
   );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: scan-timing master for an 800x480 RGB panel.
// Issues vga_h/vga_v to the compositor, takes the returned pixel
// PIXEL_LATENCY clocks later and drives rgb/de/hsync/vsync aligned to it.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern
// selected by test_mode.
module vga_timing #(
   parameter int H_ACTIVE      = 800,
   parameter int H_FP          = 40,
   parameter int H_SYNC        = 48,
   parameter int H_BP          = 40,
   parameter int V_ACTIVE      = 480,
   parameter int V_FP          = 13,
   parameter int V_SYNC        = 3,
   parameter int V_BP          = 29,
   parameter bit H_SYNC_POL    = 1'b0,
   parameter bit V_SYNC_POL    = 1'b0,
   parameter int PIXEL_LATENCY = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   vga_timing_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // Depth of the strobe pipes: pixel latency plus the rgb output register.
   localparam int L       = PIXEL_LATENCY + 1;

   localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
   localparam logic [10:0] H_FP_LAST  = 11'(H_ACTIVE + H_FP - 1);
   localparam logic [10:0] H_SYN_LAST = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] H_TOT_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
   localparam logic [10:0] V_FP_LAST  = 11'(V_ACTIVE + V_FP - 1);
   localparam logic [10:0] V_SYN_LAST = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [10:0] V_TOT_LAST = 11'(V_TOTAL - 1);

   typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYN, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYN, V_BACK} v_state_t;

   h_state_t    h_state_q, h_state_d;
   v_state_t    v_state_q, v_state_d;
   logic [10:0] h_q, h_d;
   logic [10:0] v_q, v_d;
   logic        h_wrap;

   logic        de_raw, hs_raw, vs_raw, fs_raw;
   logic [L-1:0] de_pipe_q, de_pipe_d;
   logic [L-1:0] hs_pipe_q, hs_pipe_d;
   logic [L-1:0] vs_pipe_q, vs_pipe_d;
   logic [L-1:0] fs_pipe_q, fs_pipe_d;
   logic [23:0] rgb_q, rgb_d;
   logic [23:0] rgb_src;
   // de delayed to line up with pixel_in (one stage short of the output).
   logic        de_align;

   // Horizontal counter and phase FSM.
   always_comb begin
      h_wrap    = (h_q == H_TOT_LAST);
      h_d       = h_wrap ? '0 : h_q + 11'd1;
      h_state_d = h_state_q;
      case (h_state_q)
         H_ACT:   if (h_q == H_ACT_LAST) h_state_d = H_FRONT;
         H_FRONT: if (h_q == H_FP_LAST)  h_state_d = H_SYN;
         H_SYN:   if (h_q == H_SYN_LAST) h_state_d = H_BACK;
         H_BACK:  if (h_wrap)            h_state_d = H_ACT;
         default:                        h_state_d = H_ACT;
      endcase
   end

   // Vertical counter and phase FSM, advancing only on a horizontal wrap.
   always_comb begin
      v_d       = v_q;
      v_state_d = v_state_q;
      if (h_wrap) begin
         v_d = (v_q == V_TOT_LAST) ? '0 : v_q + 11'd1;
         case (v_state_q)
            V_ACT:   if (v_q == V_ACT_LAST) v_state_d = V_FRONT;
            V_FRONT: if (v_q == V_FP_LAST)  v_state_d = V_SYN;
            V_SYN:   if (v_q == V_SYN_LAST) v_state_d = V_BACK;
            V_BACK:  if (v_q == V_TOT_LAST) v_state_d = V_ACT;
            default:                        v_state_d = V_ACT;
         endcase
      end
   end

   // Raw strobes decoded from the phases, then shifted into the delay pipes.
   always_comb begin
      de_raw    = (h_state_q == H_ACT) && (v_state_q == V_ACT);
      hs_raw    = (h_state_q == H_SYN);
      vs_raw    = (v_state_q == V_SYN);
      fs_raw    = (h_q == '0) && (v_q == '0);
      de_pipe_d = {de_pipe_q[L-2:0], de_raw};
      hs_pipe_d = {hs_pipe_q[L-2:0], hs_raw};
      vs_pipe_d = {vs_pipe_q[L-2:0], vs_raw};
      fs_pipe_d = {fs_pipe_q[L-2:0], fs_raw};
      de_align  = de_pipe_q[L-2];
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic [10:0] hx_pipe_q [PIXEL_LATENCY];
   logic [10:0] hx_pipe_d [PIXEL_LATENCY];
   logic [2:0]  bar_idx;
   logic [23:0] bar_rgb;

   // Horizontal index delayed to match pixel_in, then mapped to a bar colour.
   always_comb begin
      hx_pipe_d[0] = h_q;
      for (int unsigned i = 1; i < PIXEL_LATENCY; i++) begin
         hx_pipe_d[i] = hx_pipe_q[i-1];
      end
      bar_idx = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (hx_pipe_q[PIXEL_LATENCY-1] >= 11'(k * BAR_W)) bar_idx = 3'(k);
      end
      case (bar_idx)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
      rgb_src = bus.test_mode ? bar_rgb : bus.pixel_in;
   end

   // Delay line for the horizontal index used by the bar generator.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < PIXEL_LATENCY; i++) hx_pipe_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < PIXEL_LATENCY; i++) hx_pipe_q[i] <= hx_pipe_d[i];
      end
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = bus.test_mode;

   // Pixel source is always the compositor in this build.
   always_comb begin
      rgb_src = bus.pixel_in;
   end
`endif

   // Blank the panel data whenever the aligned de is low.
   always_comb begin
      rgb_d = de_align ? rgb_src : '0;
   end

   // State registers; all pipes clear to their inactive level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_q       <= '0;
         v_q       <= '0;
         h_state_q <= H_ACT;
         v_state_q <= V_ACT;
         de_pipe_q <= '0;
         hs_pipe_q <= '0;
         vs_pipe_q <= '0;
         fs_pipe_q <= '0;
         rgb_q     <= '0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         h_state_q <= h_state_d;
         v_state_q <= v_state_d;
         de_pipe_q <= de_pipe_d;
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
         fs_pipe_q <= fs_pipe_d;
         rgb_q     <= rgb_d;
      end
   end

   assign bus.vga_h       = h_q;
   assign bus.vga_v       = v_q;
   assign bus.rgb_out     = rgb_q;
   assign bus.de          = de_pipe_q[L-1];
   assign bus.hsync       = hs_pipe_q[L-1] ~^ H_SYNC_POL;
   assign bus.vsync       = vs_pipe_q[L-1] ~^ V_SYNC_POL;
   assign bus.frame_start = fs_pipe_q[L-1];

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing. Horizontal timing uses the default 928-clock
// line; the frame is shortened to 13 lines (6 active, vsync on lines 8..10)
// so two full frames fit in a short run.
module tb_vga_timing;
   localparam int HT = 928;
   localparam int VT = 13;
   localparam int L  = 2;
   localparam int FRAME = HT * VT;
   localparam logic [27:0] IDLE = {24'h000000, 4'b0110};

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   vga_timing_if bus();

   vga_timing #(
      .V_ACTIVE (6),
      .V_FP     (2),
      .V_SYNC   (3),
      .V_BP     (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [27:0] dut_out;
   assign dut_out = {bus.rgb_out, bus.de, bus.hsync, bus.vsync, bus.frame_start};

   typedef struct {
      int          h;
      int          v;
      logic [27:0] exp;
      string       name;
   } vec_t;

   vec_t        tbl[$];
   logic [27:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc;
   int          mh, mv;
   logic [10:0] ph, pv;
   bit          tp = 1'b0;
   int          de_run, hs_low, vs_low, since0, last_fs;
   logic        prev_de, prev_hs, prev_vs;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [23:0] bar_rgb(input int h);
      case (h / 100)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Expected panel outputs for the coordinate (h, v).
   function automatic logic [27:0] expo(input int h, input int v);
      logic de, hs, vs, fs;
      logic [23:0] rgb;
      logic [10:0] hh, vv;
      hh  = 11'(h);
      vv  = 11'(v);
      de  = (h < 800) && (v < 6);
      hs  = !((h >= 840) && (h < 888));
      vs  = !((v >= 8) && (v < 11));
      fs  = (h == 0) && (v == 0);
      rgb = !de ? 24'h0 : (tp ? bar_rgb(h) : {hh[7:0], vv[7:0], 8'hA5});
      return {rgb, de, hs, vs, fs};
   endfunction

   task automatic restart();
      cyc = 0;
      mh  = 0;
      mv  = 0;
      exp_q.delete();
      for (int i = 0; i < L; i++) exp_q.push_back(IDLE);
      ph = 11'h7FF;
      pv = 11'h7FF;
      de_run = 0; hs_low = 0; vs_low = 0; since0 = 0; last_fs = -1;
      prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
   endtask

   // Per-cycle scoreboard, run-length trackers and compositor model.
   task automatic sample();
      logic [27:0] got;
      chk("coords", {bus.vga_h, bus.vga_v}, {11'(mh), 11'(mv)});
      exp_q.push_back(expo(mh, mv));
      got = exp_q.pop_front();
      chk("outputs", dut_out, got);

      if (bus.vga_h == 11'd0) since0 = 0; else since0++;
      if (bus.de) de_run++;
      else begin
         if (prev_de) chk("de_run", de_run, 800);
         de_run = 0;
      end
      if (!bus.hsync) begin
         if (prev_hs) chk("hs_start", since0, 842);
         hs_low++;
      end else begin
         if (!prev_hs) chk("hs_width", hs_low, 48);
         hs_low = 0;
      end
      if (!bus.vsync) vs_low++;
      else begin
         if (!prev_vs) chk("vs_width", vs_low, 3 * HT);
         vs_low = 0;
      end
      if (bus.frame_start) begin
         if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME);
         last_fs = cyc;
      end
      prev_de = bus.de;
      prev_hs = bus.hsync;
      prev_vs = bus.vsync;

      // Compositor: return the previous cycle's coordinates, garbage in blanking.
      if (ph < 11'd800 && pv < 11'd6) bus.pixel_in = {ph[7:0], pv[7:0], 8'hA5};
      else bus.pixel_in = 24'($urandom);
      ph = bus.vga_h;
      pv = bus.vga_v;

      mh++;
      if (mh == HT) begin
         mh = 0;
         mv++;
         if (mv == VT) mv = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      sample();
   endtask

   // Output for coordinate index n appears L cycles after it is issued.
   task automatic run_table();
      int tgt;
      for (int i = 0; i < tbl.size(); i++) begin
         tgt = tbl[i].v * HT + tbl[i].h + L;
         while (cyc < tgt) step();
         chk(tbl[i].name, dut_out, tbl[i].exp);
      end
   endtask

   initial begin
      bit hit;
      reset_n       = 1'b0;
      bus.pixel_in  = '0;
      bus.test_mode = 1'b0;
      cyc           = 0;
      repeat (3) @(negedge clk);
      chk("reset_state", {bus.vga_h, bus.vga_v, dut_out}, {22'd0, IDLE});

      reset_n = 1'b1;
      #1;
      restart();
      sample();

      // {h, v, {rgb, de, hsync, vsync, frame_start}} on the output timeline.
      tbl.push_back('{0,   0,  {24'h0000A5, 4'b1111}, "px_0_0"});
      tbl.push_back('{1,   0,  {24'h0100A5, 4'b1110}, "px_1_0"});
      tbl.push_back('{799, 0,  {24'h1F00A5, 4'b1110}, "px_799_0"});
      tbl.push_back('{800, 0,  {24'h000000, 4'b0110}, "hfp_first"});
      tbl.push_back('{839, 0,  {24'h000000, 4'b0110}, "hfp_last"});
      tbl.push_back('{840, 0,  {24'h000000, 4'b0010}, "hsync_first"});
      tbl.push_back('{887, 0,  {24'h000000, 4'b0010}, "hsync_last"});
      tbl.push_back('{888, 0,  {24'h000000, 4'b0110}, "hbp_first"});
      tbl.push_back('{927, 0,  {24'h000000, 4'b0110}, "line_end"});
      tbl.push_back('{0,   1,  {24'h0001A5, 4'b1110}, "px_0_1"});
      tbl.push_back('{5,   3,  {24'h0503A5, 4'b1110}, "px_5_3"});
      tbl.push_back('{799, 5,  {24'h1F05A5, 4'b1110}, "px_799_5"});
      tbl.push_back('{0,   6,  {24'h000000, 4'b0110}, "vblank_first"});
      tbl.push_back('{100, 8,  {24'h000000, 4'b0100}, "vsync_first"});
      tbl.push_back('{927, 10, {24'h000000, 4'b0100}, "vsync_last"});
      tbl.push_back('{0,   11, {24'h000000, 4'b0110}, "vbp_first"});
      tbl.push_back('{0,   13, {24'h0000A5, 4'b1111}, "frame2_start"});
      run_table();

      while (cyc < 2 * FRAME + 2000) step();

      // Reset in the middle of an hsync and vsync pulse.
      hit = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (bus.vga_h == 11'd860 && bus.vga_v == 11'd9) begin
            hit = 1'b1;
            break;
         end
         step();
      end
      chk("reach_mid_frame", 64'(hit), 64'd1);
      chk("syncs_active_before_reset", {bus.hsync, bus.vsync}, 2'b00);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_reset_async", {bus.vga_h, bus.vga_v, dut_out}, {22'd0, IDLE});
      repeat (2) @(negedge clk);
`ifdef VGA_TEST_PATTERN_EN
      bus.test_mode = 1'b1;
      tp = 1'b1;
`endif
      reset_n = 1'b1;
      #1;
      restart();
      sample();
`ifdef VGA_TEST_PATTERN_EN
      tbl.delete();
      tbl.push_back('{0,   0, {24'hFFFFFF, 4'b1111}, "bar_white"});
      tbl.push_back('{100, 0, {24'hFFFF00, 4'b1110}, "bar_yellow"});
      tbl.push_back('{799, 0, {24'h000000, 4'b1110}, "bar_black_end"});
      tbl.push_back('{800, 0, {24'h000000, 4'b0110}, "bar_de_off"});
      run_table();
`endif
      while (cyc < 2000) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Timing master at the display end of the pixel interface. Generates the vga_h/vga_v scan coordinates that the frame compositor consumes.
- Accepts the compositor's returned 24-bit pixel, delay-matches the panel sync and data-enable strobes to it, and drives the 800x480 RGB panel.
- One instance per design, sitting between the compositor and the panel pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 48, hsync pulse width (clocks)
- H_BP, 40, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- H_SYNC_POL, 0, 1 = hsync active high, 0 = active low
- V_SYNC_POL, 0, 1 = vsync active high, 0 = active low
- PIXEL_LATENCY, 1, clocks from vga_h/vga_v to a valid pixel_in (range 1..4)

Ports:
- clk  in  1  pixel clock, all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pixel_in  in  24  RGB pixel returned by the compositor for the coordinates issued PIXEL_LATENCY clocks earlier
- test_mode  in  1  selects the test pattern; only used when VGA_TEST_PATTERN_EN is defined
- vga_h  out  11  current horizontal count, 0..H_TOTAL-1
- vga_v  out  11  current vertical count, 0..V_TOTAL-1
- rgb_out  out  24  panel pixel data
- de  out  1  panel data enable
- hsync  out  1  panel horizontal sync
- vsync  out  1  panel vertical sync
- frame_start  out  1  one-clock pulse that accompanies the first active pixel of each frame on rgb_out

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 928. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Horizontal FSM: H_ACT (h < 800) -> H_FRONT (800..839) -> H_SYN (840..887) -> H_BACK (888..927) -> H_ACT. The vertical FSM uses the same four phases over line indices and advances only on a horizontal wrap.
- Counters:
  - vga_h increments every clock and wraps from H_TOTAL-1 to 0.
  - vga_v increments when vga_h wraps, and wraps from V_TOTAL-1 to 0 on the same clock that vga_h wraps.
  - vga_h and vga_v are registered outputs.
- Raw (undelayed) strobes:
  - de_raw = (vga_h < H_ACTIVE) && (vga_v < V_ACTIVE).
  - hs_raw is asserted for 840 <= vga_h < 888.
  - vs_raw is asserted for 493 <= vga_v < 496, for every clock of those lines.
- Alignment:
  - de_raw, hs_raw and vs_raw pass through a shift register of depth L = PIXEL_LATENCY+1.
  - rgb_out registers pixel_in when the delayed de is high, and registers 24'h000000 otherwise.
  - Total latency from coordinates to the panel outputs is L clocks (2 by default); de, hsync, vsync and rgb_out stay mutually aligned.
- Sync polarity: hsync = delayed hs_raw XNOR H_SYNC_POL. vsync is formed the same way with V_SYNC_POL.
- frame_start = delayed version of (vga_h==0 && vga_v==0), through the same depth-L pipe.
- Reset (async assert, sync release):
  - vga_h=0, vga_v=0, rgb_out=0, de=0, frame_start=0.
  - hsync and vsync are held at their inactive levels (!H_SYNC_POL, !V_SYNC_POL); the delay pipes clear to inactive.
  - The first rising edge after release advances vga_h to 1. The first pixel (0,0) appears on the outputs L clocks after release.
- Reset asserted mid-frame: all outputs reach their reset values immediately, with no partial sync pulse held. On release, scanning restarts at (0,0).
- pixel_in is ignored while the delayed de is low; no X propagates to rgb_out in the blanking intervals.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: while test_mode=1, the rgb_out source is 8 vertical colour bars, each 100 pixels wide, taken from the delayed horizontal index. Bar order from left: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Timing and latency are identical to normal operation.
- Not defined: test_mode is ignored and no bar logic is synthesised.

Test Plan:
- Reset release -> vga_h counts 0,1,2... with vga_v=0. de first rises exactly 2 clocks after the clock on which vga_h=0, and frame_start pulses alongside it.
- Run one full line -> de is high for exactly 800 clocks. hsync is low for 48 clocks, starting 842 clocks after vga_h=0 on the output timeline (840+L). vga_h wraps 927 -> 0 and vga_v increments.
- Run 2 frames -> vsync is low for exactly 3x928 = 2784 clocks per frame. The frame period is 928x525 = 487200 clocks, and vga_v wraps 524 -> 0.
- Drive pixel_in = {vga_h[7:0], vga_v[7:0], 8'hA5}, delayed by 1 clock -> rgb_out at active pixel (5,3) equals 0503A5. rgb_out is 000000 during all blanking.
- Assert reset_n low at vga_h=300, vga_v=200 -> outputs reach their reset values in the same cycle with no clock edge required. After release, scanning resumes at (0,0).
- With VGA_TEST_PATTERN_EN defined and test_mode=1 -> rgb_out is FFFFFF for pixel 0 and FFFF00 for pixel 100. Pixel 799 is 000000, and de timing is unchanged.
